norm_shifter: RTL and testbench

NORM_SHIFTER -- requirements
Module: norm_shifter

---
 rtl/fphub_pkg.sv | 23 ++
 rtl/lz_window.sv | 28 ++
 rtl/norm_shifter.sv | 155 +++++++++++++++
 tb/tb_norm_shifter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fphub_pkg.sv
// Shared definitions for the HUB floating-point datapath: the normaliser
// FSM state encoding and the mantissa/shift width derivations.
package fphub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Magnitude width once the sign bit has been stripped from the extended mantissa.
   function automatic int calc_w(input int m, input int extra_bits, input int sign_bit);
      return m + extra_bits - sign_bit;
   endfunction

   function automatic int calc_shift_width(input int w);
      return $clog2(w - 1);
   endfunction

   localparam int W_DEFAULT           = calc_w(23, 7, 1);
   localparam int SHIFT_WIDTH_DEFAULT = calc_shift_width(W_DEFAULT);

endpackage

// File: rtl/lz_window.sv
// Leading-zero count over the top STEP bits of a magnitude, saturating at STEP.
// Purely combinational; bounds how far the normaliser may shift in one cycle.
module lz_window #(
   parameter int W    = 29,
   parameter int STEP = 4,
   parameter int ZW   = 6
) (
   input  logic [W-1:0]  mant,
   output logic [ZW-1:0] z
);

   logic found_s;

   // Scan from the MSB down; the first set bit fixes the count.
   always_comb begin
      found_s = 1'b0;
      z       = ZW'(STEP);
      for (int i = 0; i < STEP; i++) begin
         if (!found_s && mant[W-1-i]) begin
            z       = ZW'(i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/norm_shifter.sv
// Iterative mantissa normaliser: shifts the magnitude left by at most STEP
// positions per cycle until its MSB is set, adjusting the exponent and
// flushing to zero when the exponent would reach or pass 0.
module norm_shifter
   import fphub_pkg::*;
#(
   parameter  int M                   = 23,
   parameter  int extra_bits_mantissa = 7,
   parameter  int sign_mantissa_bit   = 1,
   parameter  int E                   = 8,
   parameter  int STEP                = 4,
   localparam int W                   = calc_w(M, extra_bits_mantissa, sign_mantissa_bit),
   localparam int SHIFT_WIDTH         = calc_shift_width(W)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_mant,
   input  logic [E-1:0]           in_exp,
   input  logic                   in_sign,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_mant,
   output logic [E-1:0]           out_exp,
   output logic                   out_sign,
   output logic [SHIFT_WIDTH:0]   out_shift,
   output logic                   out_zero,
   output logic                   out_underflow
);

   localparam int ZW = SHIFT_WIDTH + 1;
   localparam int CW = (E > ZW) ? E : ZW;

   state_e              state_q, state_d;
   logic [W-1:0]        mant_q, mant_d;
   logic [E-1:0]        exp_q, exp_d;
   logic                sign_q, sign_d;
   logic [ZW-1:0]       count_q, count_d;
   logic                zero_q, zero_d;
   logic                underflow_q, underflow_d;

   logic [ZW-1:0]       z_s;
   logic [CW-1:0]       exp_ext_s;
   logic [CW-1:0]       z_ext_s;

   lz_window #(
      .W    (W),
      .STEP (STEP),
      .ZW   (ZW)
   ) u_lz_window (
      .mant (mant_q),
      .z    (z_s)
   );

   assign exp_ext_s = CW'(exp_q);
   assign z_ext_s   = CW'(z_s);

   // Next-state and datapath update for the accept / shift / hold sequence.
   always_comb begin
      state_d     = state_q;
      mant_d      = mant_q;
      exp_d       = exp_q;
      sign_d      = sign_q;
      count_d     = count_q;
      zero_d      = zero_q;
      underflow_d = underflow_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d      = in_sign;
               underflow_d = 1'b0;
               if (in_mant == {W{1'b0}}) begin
                  // Zero reports the detector's all-zero code and skips shifting.
                  mant_d  = {W{1'b0}};
                  exp_d   = {E{1'b0}};
                  count_d = {1'b1, {SHIFT_WIDTH{1'b0}}};
                  zero_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  mant_d  = in_mant;
                  exp_d   = in_exp;
                  count_d = {ZW{1'b0}};
                  zero_d  = 1'b0;
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (z_s == {ZW{1'b0}}) begin
               state_d = DONE;
            end else if (exp_ext_s <= z_ext_s) begin
               mant_d      = {W{1'b0}};
               exp_d       = {E{1'b0}};
               underflow_d = 1'b1;
               state_d     = DONE;
            end else begin
               mant_d  = mant_q << z_s;
               exp_d   = exp_q - E'(z_s);
               count_d = count_q + z_s;
               // A saturated window may hide more zeros, so look again.
               if (z_s < ZW'(STEP)) begin
                  state_d = DONE;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mant_q      <= {W{1'b0}};
         exp_q       <= {E{1'b0}};
         sign_q      <= 1'b0;
         count_q     <= {ZW{1'b0}};
         zero_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mant_q      <= mant_d;
         exp_q       <= exp_d;
         sign_q      <= sign_d;
         count_q     <= count_d;
         zero_q      <= zero_d;
         underflow_q <= underflow_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign out_mant      = mant_q;
   assign out_exp       = exp_q;
   assign out_sign      = sign_q;
   assign out_shift     = count_q;
   assign out_zero      = zero_q;
   assign out_underflow = underflow_q;

endmodule

// File: tb/tb_norm_shifter.sv
// Directed self-checking bench for norm_shifter with hand-computed vectors
// for W=29, E=8, STEP=4.
module tb_norm_shifter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [28:0] in_mant;
   logic [7:0]  in_exp;
   logic        in_sign;
   logic        out_valid;
   logic        out_ready;
   logic [28:0] out_mant;
   logic [7:0]  out_exp;
   logic        out_sign;
   logic [5:0]  out_shift;
   logic        out_zero;
   logic        out_underflow;

   int n_checks;
   int n_errors;

   norm_shifter dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_mant       (in_mant),
      .in_exp        (in_exp),
      .in_sign       (in_sign),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_mant      (out_mant),
      .out_exp       (out_exp),
      .out_sign      (out_sign),
      .out_shift     (out_shift),
      .out_zero      (out_zero),
      .out_underflow (out_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operand, measure latency, check the result, optionally stall.
   task automatic run_op(input string tag, input logic [28:0] mant, input logic [7:0] ex,
                         input logic sg, input int lat, input logic [28:0] e_mant,
                         input logic [7:0] e_exp, input logic [5:0] e_sh,
                         input logic e_zero, input logic e_uf, input int hold);
      int c;
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_mant  = mant;
      in_exp   = ex;
      in_sign  = sg;
      tick();
      in_valid = 1'b0;
      in_mant  = 29'd0;
      in_exp   = 8'd0;
      in_sign  = 1'b0;
      c = 1;
      while (!out_valid && c < 50) begin
         tick();
         c++;
      end
      chk({tag, ".latency"}, 64'(c), 64'(lat));
      chk({tag, ".mant"}, 64'(out_mant), 64'(e_mant));
      chk({tag, ".exp"}, 64'(out_exp), 64'(e_exp));
      chk({tag, ".shift"}, 64'(out_shift), 64'(e_sh));
      chk({tag, ".zero"}, 64'(out_zero), 64'(e_zero));
      chk({tag, ".uf"}, 64'(out_underflow), 64'(e_uf));
      chk({tag, ".sign"}, 64'(out_sign), 64'(sg));
      for (int h = 0; h < hold; h++) begin
         if (h == 2) begin
            in_valid = 1'b1;
            in_mant  = 29'd3;
            in_exp   = 8'd77;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         in_valid = 1'b0;
         chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
         chk({tag, ".hold_mant"}, 64'(out_mant), 64'(e_mant));
         chk({tag, ".hold_exp"}, 64'(out_exp), 64'(e_exp));
         chk({tag, ".hold_shift"}, 64'(out_shift), 64'(e_sh));
      end
      in_mant   = 29'd0;
      in_exp    = 8'd0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".back_idle"}, 64'(in_ready), 64'd1);
      chk({tag, ".valid_low"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mant   = 29'd0;
      in_exp    = 8'd0;
      in_sign   = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.mant", 64'(out_mant), 64'd0);
      chk("rst.exp", 64'(out_exp), 64'd0);
      chk("rst.shift", 64'(out_shift), 64'd0);
      chk("rst.zero", 64'(out_zero), 64'd0);
      chk("rst.uf", 64'(out_underflow), 64'd0);
      chk("rst.sign", 64'(out_sign), 64'd0);
      tick();
      tick();
      rst = 1'b0;

      // First accept immediately after reset release.
      run_op("norm0", 29'h1000_0000, 8'd100, 1'b0, 2, 29'h1000_0000, 8'd100, 6'd0, 1'b0, 1'b0, 0);
      run_op("lz8", 29'h0010_0000, 8'd100, 1'b1, 4, 29'h1000_0000, 8'd92, 6'd8, 1'b0, 1'b0, 0);
      run_op("lz7", 29'h0020_0000, 8'd100, 1'b0, 3, 29'h1000_0000, 8'd93, 6'd7, 1'b0, 1'b0, 0);
      run_op("zero", 29'd0, 8'd55, 1'b1, 1, 29'd0, 8'd0, 6'd32, 1'b1, 1'b0, 0);
      run_op("uf1", 29'd1, 8'd10, 1'b0, 4, 29'd0, 8'd0, 6'd8, 1'b0, 1'b1, 0);
      run_op("lz28", 29'd1, 8'd100, 1'b0, 9, 29'h1000_0000, 8'd72, 6'd28, 1'b0, 1'b0, 0);
      run_op("uf_eq", 29'h0080_0000, 8'd5, 1'b0, 3, 29'd0, 8'd0, 6'd4, 1'b0, 1'b1, 0);
      run_op("exp_gt", 29'h0100_0000, 8'd5, 1'b1, 3, 29'h1000_0000, 8'd1, 6'd4, 1'b0, 1'b0, 0);
      run_op("hold", 29'h0020_0000, 8'd100, 1'b1, 3, 29'h1000_0000, 8'd93, 6'd7, 1'b0, 1'b0, 5);

      // Reset in the second SHIFT cycle aborts the operand.
      in_valid = 1'b1;
      in_mant  = 29'h0010_0000;
      in_exp   = 8'd100;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("abort.in_ready", 64'(in_ready), 64'd1);
      chk("abort.out_valid", 64'(out_valid), 64'd0);
      chk("abort.mant", 64'(out_mant), 64'd0);
      chk("abort.shift", 64'(out_shift), 64'd0);
      #2;
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen++;
         end
         chk("abort.no_valid", 64'(seen), 64'd0);
      end
      run_op("after", 29'h0010_0000, 8'd100, 1'b0, 4, 29'h1000_0000, 8'd92, 6'd8, 1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
